// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (read-only) and the memory stage (load/store).
// The data side wins ties, but a fairness counter caps consecutive data grants while fetch waits.
module mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_CONSEC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRdata,
    output logic          IValid,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWdata,
    output logic [DW-1:0] DRdata,
    output logic          DValid,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemReady,
    output logic          StallF,
    output logic          StallM,
    output logic          Busy
);

    localparam int unsigned  CW   = $clog2(MAX_D_CONSEC + 1);
    localparam logic [CW-1:0] DMax = CW'(MAX_D_CONSEC);

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic          w_ei;
    logic          w_ed;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_done;
    logic          w_busy;

    logic [CW-1:0] r_dcount;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_irdata;
    logic [DW-1:0] r_drdata;
    logic          r_ivalid;
    logic          r_dvalid;

    // A requester in its valid cycle still shows the access just served; mask it out.
    assign w_ei = IReq & ~r_ivalid;
    assign w_ed = DReq & ~r_dvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_ed && (!w_ei || (r_dcount < DMax))) begin
                    w_state_next = StServeD;
                end else if (w_ei) begin
                    w_state_next = StServeI;
                end
            end
            StServeI, StServeD: begin
                if (MemReady) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_done    = 1'b0;
        w_busy    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_grant_d = (w_state_next == StServeD);
                w_grant_i = (w_state_next == StServeI);
            end
            StServeI, StServeD: begin
                w_busy = 1'b1;
                w_done = MemReady;
            end
            default: ;
        endcase
    end

    // Memory-side request registers: loaded on grant, held while serving, dropped on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= DWe;
            r_mem_addr  <= DAddr;
            r_mem_wdata <= DWdata;
        end else if (w_grant_i) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= IAddr;
        end else if (w_done) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irdata <= '0;
            r_drdata <= '0;
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            r_ivalid <= w_done && (r_state == StServeI);
            r_dvalid <= w_done && (r_state == StServeD);
            if (w_done && (r_state == StServeI)) begin
                r_irdata <= MemRdata;
            end
            if (w_done && (r_state == StServeD)) begin
                r_drdata <= MemRdata;
            end
        end
    end

    // Counts data grants that overtook a pending fetch; any fetch grant restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dcount <= '0;
        end else if (w_grant_d) begin
            if (!w_ei) begin
                r_dcount <= '0;
            end else if (r_dcount != DMax) begin
                r_dcount <= r_dcount + 1'b1;
            end
        end else if (w_grant_i) begin
            r_dcount <= '0;
        end
    end

    assign MemReq   = r_mem_req;
    assign MemWe    = r_mem_we;
    assign MemAddr  = r_mem_addr;
    assign MemWdata = r_mem_wdata;
    assign IRdata   = r_irdata;
    assign DRdata   = r_drdata;
    assign IValid   = r_ivalid;
    assign DValid   = r_dvalid;
    assign StallF   = IReq & ~r_ivalid;
    assign StallM   = DReq & ~r_dvalid;
    assign Busy     = w_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          IReq;
    logic [AW-1:0] IAddr;
    logic [DW-1:0] IRdata;
    logic          IValid;
    logic          DReq;
    logic          DWe;
    logic [AW-1:0] DAddr;
    logic [DW-1:0] DWdata;
    logic [DW-1:0] DRdata;
    logic          DValid;
    logic          MemReq;
    logic          MemWe;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWdata;
    logic [DW-1:0] MemRdata;
    logic          MemReady;
    logic          StallF;
    logic          StallM;
    logic          Busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .MAX_D_CONSEC(MAXD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .IReq    (IReq),
        .IAddr   (IAddr),
        .IRdata  (IRdata),
        .IValid  (IValid),
        .DReq    (DReq),
        .DWe     (DWe),
        .DAddr   (DAddr),
        .DWdata  (DWdata),
        .DRdata  (DRdata),
        .DValid  (DValid),
        .MemReq  (MemReq),
        .MemWe   (MemWe),
        .MemAddr (MemAddr),
        .MemWdata(MemWdata),
        .MemRdata(MemRdata),
        .MemReady(MemReady),
        .StallF  (StallF),
        .StallM  (StallM),
        .Busy    (Busy)
    );

    always #5 clk = ~clk;

    // Reference model: owner 0 = nobody, 1 = fetch, 2 = data.
    int          m_owner;
    int          m_dcount;
    logic        m_memreq, m_memwe, m_ivalid, m_dvalid;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    int          m_grants[$];

    always @(posedge clk) begin : ref_model
        bit ei, ed, nxi, nxd;
        if (reset) begin
            m_owner  = 0;
            m_dcount = 0;
            m_memreq = 0;
            m_memwe  = 0;
            m_ivalid = 0;
            m_dvalid = 0;
            m_addr   = 0;
            m_wdata  = 0;
            m_irdata = 0;
            m_drdata = 0;
        end else begin
            ei  = IReq && !m_ivalid;
            ed  = DReq && !m_dvalid;
            nxi = 0;
            nxd = 0;
            if (m_owner == 0) begin
                if (ed && (!ei || m_dcount < MAXD)) begin
                    m_owner  = 2;
                    m_memreq = 1;
                    m_memwe  = DWe;
                    m_addr   = DAddr;
                    m_wdata  = DWdata;
                    m_dcount = ei ? ((m_dcount + 1 > MAXD) ? MAXD : m_dcount + 1) : 0;
                    m_grants.push_back(2);
                end else if (ei) begin
                    m_owner  = 1;
                    m_memreq = 1;
                    m_memwe  = 0;
                    m_addr   = IAddr;
                    m_dcount = 0;
                    m_grants.push_back(1);
                end
            end else if (MemReady) begin
                if (m_owner == 1) begin
                    m_irdata = MemRdata;
                    nxi      = 1;
                end else begin
                    m_drdata = MemRdata;
                    nxd      = 1;
                end
                m_owner  = 0;
                m_memreq = 0;
                m_memwe  = 0;
            end
            m_ivalid = nxi;
            m_dvalid = nxd;
        end
    end

    // Memory responder: random latency, occasional stray MemReady while idle.
    bit mem_auto    = 0;
    bit agent_pulse = 0;
    int lat         = 0;

    always @(negedge clk) begin
        if (agent_pulse) begin
            MemReady    = 1'b0;
            agent_pulse = 0;
        end else if (mem_auto) begin
            if (MemReq) begin
                if (lat == 0) begin
                    MemReady    = 1'b1;
                    MemRdata    = $urandom;
                    agent_pulse = 1;
                    lat         = $urandom_range(0, 3);
                end else begin
                    lat = lat - 1;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                MemReady    = 1'b1;
                MemRdata    = $urandom;
                agent_pulse = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({MemReq, MemWe, IValid, DValid, Busy} !== 5'b0 || MemAddr !== 0 || MemWdata !== 0 ||
            IRdata !== 0 || DRdata !== 0) begin
            n_fail++;
            $display("FAIL reset_values: req=%b we=%b iv=%b dv=%b busy=%b addr=%h wd=%h ir=%h dr=%h, need all 0",
                     MemReq, MemWe, IValid, DValid, Busy, MemAddr, MemWdata, IRdata, DRdata);
        end
        reset  = 1'b0;
        DReq   = 1'b1;
        DWe    = 1'b1;
        DAddr  = 32'h300;
        DWdata = 32'hA5A5A5A5;
        tick();
        n_tests++;
        if (MemReq !== 1'b1 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_serve: req=%b busy=%b, need 1 1", MemReq, Busy);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        DReq  = 1'b0;
        n_tests++;
        if (MemReq !== 1'b0 || Busy !== 1'b0 || MemWe !== 1'b0 || MemAddr !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_serve: req=%b busy=%b we=%b addr=%h, need 0", MemReq, Busy,
                     MemWe, MemAddr);
        end
        tick();
        MemReady = 1'b1;
        MemRdata = 32'hFFFF0000;
        tick();
        MemReady = 1'b0;
        n_tests++;
        if (DValid !== 1'b0 || Busy !== 1'b0 || MemReq !== 1'b0 || DRdata !== 0) begin
            n_fail++;
            $display("FAIL reset_late_ready: dv=%b busy=%b req=%b dr=%h, need 0 0 0 0", DValid,
                     Busy, MemReq, DRdata);
        end
        tick();
        n_tests++;
        if (DValid !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stays_idle: dv=%b busy=%b, need 0 0", DValid, Busy);
        end
    endtask

    task automatic test_fetch_only();
        IReq  = 1'b1;
        IAddr = 32'h10;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (MemReq !== 1'b1 || MemAddr !== 32'h10 || MemWe !== 1'b0 || StallF !== 1'b1 ||
                IValid !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_hold[%0d]: req=%b addr=%h we=%b stallf=%b iv=%b, need 1 10 0 1 0",
                         k, MemReq, MemAddr, MemWe, StallF, IValid);
            end
            if (k == 2) begin
                MemReady = 1'b1;
                MemRdata = 32'hE2811001;
            end
            tick();
        end
        MemReady = 1'b0;
        n_tests++;
        if (IValid !== 1'b1 || IRdata !== 32'hE2811001 || StallF !== 1'b0 || MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_done: iv=%b ir=%h stallf=%b req=%b, need 1 e2811001 0 0", IValid,
                     IRdata, StallF, MemReq);
        end
        IReq = 1'b0;
        tick();
        n_tests++;
        if (IValid !== 1'b0 || IRdata !== 32'hE2811001 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_after: iv=%b ir=%h busy=%b, need 0 e2811001 0", IValid, IRdata,
                     Busy);
        end
    endtask

    task automatic test_store_then_fetch();
        IReq   = 1'b1;
        IAddr  = 32'h20;
        DReq   = 1'b1;
        DWe    = 1'b1;
        DAddr  = 32'h100;
        DWdata = 32'hDEADBEEF;
        tick();
        n_tests++;
        if (MemReq !== 1'b1 || MemWe !== 1'b1 || MemAddr !== 32'h100 ||
            MemWdata !== 32'hDEADBEEF || StallF !== 1'b1 || StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL store_grant: req=%b we=%b addr=%h wd=%h sf=%b sm=%b, need 1 1 100 deadbeef 1 1",
                     MemReq, MemWe, MemAddr, MemWdata, StallF, StallM);
        end
        MemReady = 1'b1;
        MemRdata = 32'h55AA55AA;
        tick();
        MemReady = 1'b0;
        n_tests++;
        if (DValid !== 1'b1 || StallM !== 1'b0 || StallF !== 1'b1 || MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done: dv=%b sm=%b sf=%b req=%b, need 1 0 1 0", DValid, StallM,
                     StallF, MemReq);
        end
        DReq = 1'b0;
        tick();
        n_tests++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h20 || MemWe !== 1'b0 || StallF !== 1'b1 ||
            DValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_after_store: req=%b addr=%h we=%b sf=%b dv=%b, need 1 20 0 1 0",
                     MemReq, MemAddr, MemWe, StallF, DValid);
        end
        MemReady = 1'b1;
        MemRdata = 32'h0BADF00D;
        tick();
        MemReady = 1'b0;
        n_tests++;
        if (IValid !== 1'b1 || IRdata !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL fetch2_done: iv=%b ir=%h, need 1 0badf00d", IValid, IRdata);
        end
        IReq = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        int dut_log[$];
        bit prev = 0;
        bit done = 0;
        m_grants.delete();
        mem_auto = 1;
        IReq     = 1'b1;
        IAddr    = 32'h1000;
        DReq     = 1'b1;
        DWe      = 1'b0;
        DAddr    = 32'h2000;
        for (int c = 0; c < 400 && dut_log.size() < 10; c++) begin
            tick();
            if (MemReq && !prev) dut_log.push_back((MemAddr == 32'h2000) ? 2 : 1);
            prev = MemReq;
        end
        n_tests++;
        if (dut_log.size() < 10 || m_grants.size() < 10) begin
            n_fail++;
            $display("FAIL fair_count: dut grants=%0d model grants=%0d, need >=10", dut_log.size(),
                     m_grants.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_tests++;
                if (dut_log[i] !== m_grants[i]) begin
                    n_fail++;
                    $display("FAIL fair_order[%0d]: got %0d, need %0d", i, dut_log[i], m_grants[i]);
                end
            end
        end
        for (int c = 0; c < 100; c++) begin
            if (IValid) IReq = 1'b0;
            if (DValid) DReq = 1'b0;
            if (!IReq && !DReq && !Busy) begin
                done = 1;
                break;
            end
            tick();
        end
        mem_auto = 0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL fair_drain: busy=%b ireq=%b dreq=%b, need drained", Busy, IReq, DReq);
        end
        tick();
        tick();
    endtask

    task automatic test_load_no_regrant();
        DReq  = 1'b1;
        DWe   = 1'b0;
        DAddr = 32'h200;
        tick();
        n_tests++;
        if (MemReq !== 1'b1 || MemWe !== 1'b0 || MemAddr !== 32'h200) begin
            n_fail++;
            $display("FAIL load_grant: req=%b we=%b addr=%h, need 1 0 200", MemReq, MemWe, MemAddr);
        end
        MemReady = 1'b1;
        MemRdata = 32'h12345678;
        tick();
        MemReady = 1'b0;
        n_tests++;
        if (DValid !== 1'b1 || DRdata !== 32'h12345678 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: dv=%b dr=%h sm=%b, need 1 12345678 0", DValid, DRdata, StallM);
        end
        tick();
        n_tests++;
        if (DValid !== 1'b0 || MemReq !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_no_regrant: dv=%b req=%b busy=%b, need 0 0 0", DValid, MemReq, Busy);
        end
        DReq = 1'b0;
        tick();
    endtask

    task automatic test_ready_idle();
        MemReady = 1'b1;
        MemRdata = 32'hCAFEF00D;
        tick();
        MemReady = 1'b0;
        n_tests++;
        if (MemReq !== 1'b0 || Busy !== 1'b0 || IValid !== 1'b0 || DValid !== 1'b0 ||
            IRdata !== 32'h0BADF00D || DRdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL ready_idle: req=%b busy=%b iv=%b dv=%b ir=%h dr=%h, need 0 0 0 0 0badf00d 12345678",
                     MemReq, Busy, IValid, DValid, IRdata, DRdata);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        mem_auto = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            n_tests++;
            if (MemReq !== m_memreq || MemWe !== m_memwe || MemAddr !== m_addr ||
                MemWdata !== m_wdata || IValid !== m_ivalid || DValid !== m_dvalid ||
                IRdata !== m_irdata || DRdata !== m_drdata || Busy !== (m_owner != 0) ||
                StallF !== (IReq & ~m_ivalid) || StallM !== (DReq & ~m_dvalid)) begin
                n_fail++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL rand_cycle[%0d]: req=%b/%b we=%b/%b addr=%h/%h wd=%h/%h iv=%b/%b dv=%b/%b ir=%h/%h dr=%h/%h busy=%b/%b (got/need)",
                             c, MemReq, m_memreq, MemWe, m_memwe, MemAddr, m_addr, MemWdata,
                             m_wdata, IValid, m_ivalid, DValid, m_dvalid, IRdata, m_irdata,
                             DRdata, m_drdata, Busy, (m_owner != 0));
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            if (IReq && IValid) IReq = 1'b0;
            else if (!IReq && $urandom_range(0, 2) == 0) begin
                IReq  = 1'b1;
                IAddr = $urandom;
            end
            if (DReq && DValid) DReq = 1'b0;
            else if (!DReq && $urandom_range(0, 2) == 0) begin
                DReq   = 1'b1;
                DWe    = $urandom_range(0, 1);
                DAddr  = $urandom;
                DWdata = $urandom;
            end
        end
        mem_auto = 0;
        reset    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        IReq     = 1'b0;
        IAddr    = '0;
        DReq     = 1'b0;
        DWe      = 1'b0;
        DAddr    = '0;
        DWdata   = '0;
        MemRdata = '0;
        MemReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_fetch_only();
        test_store_then_fetch();
        test_load_no_regrant();
        test_ready_idle();
        test_fairness();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
